// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF -> EX -> MEM/WB pipeline control.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_BUBBLE,
    ST_ERROR
  } pipe_state_t;

  // ADDI x0, x0, 0 -- the instruction loaded into IF/EX when it is flushed.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in MEM writes a register that the EX
// instruction reads. x0 is hard-wired to zero, so it never creates a hazard.
// Purely combinational so the forwarding logic can share it.
module hazard_detect (
  input  logic       i_mem_is_ld,
  input  logic [4:0] i_mem_rd,
  input  logic [4:0] i_ex_rs1,
  input  logic [4:0] i_ex_rs2,
  input  logic       i_ex_use_rs1,
  input  logic       i_ex_use_rs2,
  output logic       o_lu_hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit     = i_ex_use_rs1 & (i_ex_rs1 == i_mem_rd);
  assign rs2_hit     = i_ex_use_rs2 & (i_ex_rs2 == i_mem_rd);
  assign o_lu_hazard = i_mem_is_ld & (i_mem_rd != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 3-stage pipeline.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_RUN      | normal flow; load-use and branch handled combinationally
//   ST_MEM_WAIT | data memory access outstanding, whole pipe frozen
//   ST_BUBBLE   | extra load-use bubbles beyond the first one
//   ST_ERROR    | data memory timed out; frozen until reset
//
// The release cycle out of ST_MEM_WAIT applies the same load-use/branch rules
// as ST_RUN, so a completed access costs no extra cycle and a branch held in
// EX during the wait is honoured right away.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int LU_BUBBLES  = 1
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_mem_is_ld,
  input  logic       i_mem_is_st,
  input  logic [4:0] i_mem_rd,
  input  logic [4:0] i_ex_rs1,
  input  logic [4:0] i_ex_rs2,
  input  logic       i_ex_use_rs1,
  input  logic       i_ex_use_rs2,
  input  logic       i_ex_br_taken,
  input  logic       i_dmem_ready,
  output logic       o_pc_en,
  output logic       o_if_ex_en,
  output logic       o_if_ex_flush,
  output logic       o_ex_mem_en,
  output logic       o_ex_mem_flush,
  output logic       o_dmem_req,
  output logic       o_dmem_timeout
);

  localparam int             WCW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);
  localparam logic [1:0]     LU_REM = 2'(LU_BUBBLES - 1);

  // Unsupported parameter sets are rejected at elaboration.
  if (BIT_WIDTH != 32 || MEM_TIMEOUT < 1 || LU_BUBBLES < 1 || LU_BUBBLES > 3) begin : g_bad_params
    $error("pipe_hazard_ctrl: unsupported parameter set");
  end

  pipe_state_t    state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]     bub_cnt_q, bub_cnt_d;
  logic           timeout_q, timeout_d;

  logic mem_op;
  logic lu_hazard;

  logic        run_pc_en, run_if_ex_en, run_if_ex_flush, run_ex_mem_en, run_ex_mem_flush;
  pipe_state_t run_next;
  logic [1:0]  run_bub;

  logic pc_en, if_ex_en, if_ex_flush, ex_mem_en, ex_mem_flush, dmem_req;

  assign mem_op = i_mem_is_ld | i_mem_is_st;

  hazard_detect u_hazard_detect (
    .i_mem_is_ld  (i_mem_is_ld),
    .i_mem_rd     (i_mem_rd),
    .i_ex_rs1     (i_ex_rs1),
    .i_ex_rs2     (i_ex_rs2),
    .i_ex_use_rs1 (i_ex_use_rs1),
    .i_ex_use_rs2 (i_ex_use_rs2),
    .o_lu_hazard  (lu_hazard)
  );

  // Load-use / branch / flow-through rules shared by ST_RUN and the wait release.
  always_comb begin
    run_pc_en        = 1'b1;
    run_if_ex_en     = 1'b1;
    run_if_ex_flush  = 1'b0;
    run_ex_mem_en    = 1'b1;
    run_ex_mem_flush = 1'b0;
    run_next         = ST_RUN;
    run_bub          = 2'd0;
    if (lu_hazard) begin
      // Branch operands depend on the load, so a taken branch is ignored here.
      run_pc_en        = 1'b0;
      run_if_ex_en     = 1'b0;
      run_ex_mem_flush = 1'b1;
      run_bub          = LU_REM;
      if (LU_BUBBLES > 1) begin
        run_next = ST_BUBBLE;
      end
    end else if (i_ex_br_taken) begin
      run_if_ex_flush = 1'b1;
    end
  end

  // Next-state, counters and pipeline controls.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    bub_cnt_d    = bub_cnt_q;
    timeout_d    = timeout_q;
    pc_en        = 1'b0;
    if_ex_en     = 1'b0;
    if_ex_flush  = 1'b0;
    ex_mem_en    = 1'b0;
    ex_mem_flush = 1'b0;
    dmem_req     = 1'b0;
    case (state_q)
      ST_RUN: begin
        dmem_req = mem_op;
        if (mem_op && !i_dmem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end else begin
          pc_en        = run_pc_en;
          if_ex_en     = run_if_ex_en;
          if_ex_flush  = run_if_ex_flush;
          ex_mem_en    = run_ex_mem_en;
          ex_mem_flush = run_ex_mem_flush;
          state_d      = run_next;
          bub_cnt_d    = run_bub;
        end
      end
      ST_MEM_WAIT: begin
        dmem_req = 1'b1;
        if (i_dmem_ready) begin
          pc_en        = run_pc_en;
          if_ex_en     = run_if_ex_en;
          if_ex_flush  = run_if_ex_flush;
          ex_mem_en    = run_ex_mem_en;
          ex_mem_flush = run_ex_mem_flush;
          state_d      = run_next;
          bub_cnt_d    = run_bub;
          wait_cnt_d   = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          state_d   = ST_ERROR;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ST_BUBBLE: begin
        ex_mem_en    = 1'b1;
        ex_mem_flush = 1'b1;
        if (bub_cnt_q <= 2'd1) begin
          bub_cnt_d = 2'd0;
          state_d   = ST_RUN;
        end else begin
          bub_cnt_d = bub_cnt_q - 2'd1;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      bub_cnt_q  <= 2'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bub_cnt_q  <= bub_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Reset held low freezes the pipeline regardless of state.
  assign o_pc_en        = i_rstn & pc_en;
  assign o_if_ex_en     = i_rstn & if_ex_en;
  assign o_if_ex_flush  = i_rstn & if_ex_flush;
  assign o_ex_mem_en    = i_rstn & ex_mem_en;
  assign o_ex_mem_flush = i_rstn & ex_mem_flush;
  assign o_dmem_req     = i_rstn & dmem_req;
  assign o_dmem_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver computes expected outputs
// from a behavioural model and queues them; a negedge monitor compares.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int LU_BUBBLES  = 3;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_mem_is_ld = 1'b0;
  logic       i_mem_is_st = 1'b0;
  logic [4:0] i_mem_rd = '0;
  logic [4:0] i_ex_rs1 = '0;
  logic [4:0] i_ex_rs2 = '0;
  logic       i_ex_use_rs1 = 1'b0;
  logic       i_ex_use_rs2 = 1'b0;
  logic       i_ex_br_taken = 1'b0;
  logic       i_dmem_ready = 1'b1;
  logic       o_pc_en, o_if_ex_en, o_if_ex_flush, o_ex_mem_en, o_ex_mem_flush;
  logic       o_dmem_req, o_dmem_timeout;

  always #5 i_clk = ~i_clk;

  pipe_hazard_ctrl #(
    .BIT_WIDTH   (32),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .LU_BUBBLES  (LU_BUBBLES)
  ) dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_mem_is_ld    (i_mem_is_ld),
    .i_mem_is_st    (i_mem_is_st),
    .i_mem_rd       (i_mem_rd),
    .i_ex_rs1       (i_ex_rs1),
    .i_ex_rs2       (i_ex_rs2),
    .i_ex_use_rs1   (i_ex_use_rs1),
    .i_ex_use_rs2   (i_ex_use_rs2),
    .i_ex_br_taken  (i_ex_br_taken),
    .i_dmem_ready   (i_dmem_ready),
    .o_pc_en        (o_pc_en),
    .o_if_ex_en     (o_if_ex_en),
    .o_if_ex_flush  (o_if_ex_flush),
    .o_ex_mem_en    (o_ex_mem_en),
    .o_ex_mem_flush (o_ex_mem_flush),
    .o_dmem_req     (o_dmem_req),
    .o_dmem_timeout (o_dmem_timeout)
  );

  typedef struct {
    logic [6:0] exp;
    string      tag;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  // Behavioural model: is a memory access outstanding, how long has it been
  // waiting, how many extra bubbles remain, has the memory timed out.
  bit m_waiting = 1'b0;
  int m_waited  = 0;
  int m_bubbles = 0;
  bit m_err     = 1'b0;

  function automatic bit model_hazard();
    if (!i_mem_is_ld || i_mem_rd == 5'd0) return 1'b0;
    if (i_ex_use_rs1 && i_ex_rs1 == i_mem_rd) return 1'b1;
    if (i_ex_use_rs2 && i_ex_rs2 == i_mem_rd) return 1'b1;
    return 1'b0;
  endfunction

  // Output order: pc_en, if_ex_en, if_ex_flush, ex_mem_en, ex_mem_flush, dmem_req, timeout
  function automatic logic [6:0] model_out();
    bit mem_op;
    mem_op = i_mem_is_ld || i_mem_is_st;
    if (!i_rstn) return {6'b000000, m_err};
    if (m_err) return 7'b0000001;
    if (m_bubbles > 0) return 7'b0001100;
    if (!i_dmem_ready && (m_waiting || mem_op)) return 7'b0000010;
    if (model_hazard()) return {5'b00011, (m_waiting || mem_op), 1'b0};
    if (i_ex_br_taken) return {5'b11111 & 5'b11110 | 5'b00100, (m_waiting || mem_op), 1'b0};
    return {5'b11010, (m_waiting || mem_op), 1'b0};
  endfunction

  task automatic model_step();
    bit mem_op;
    mem_op = i_mem_is_ld || i_mem_is_st;
    if (!i_rstn) begin
      m_waiting = 1'b0;
      m_waited  = 0;
      m_bubbles = 0;
      m_err     = 1'b0;
    end else if (m_err) begin
      m_err = 1'b1;
    end else if (m_bubbles > 0) begin
      m_bubbles = m_bubbles - 1;
    end else if (m_waiting && !i_dmem_ready) begin
      if (m_waited == MEM_TIMEOUT) begin
        m_err     = 1'b1;
        m_waiting = 1'b0;
      end else begin
        m_waited = m_waited + 1;
      end
    end else if (!m_waiting && mem_op && !i_dmem_ready) begin
      m_waiting = 1'b1;
      m_waited  = 1;
    end else begin
      m_waiting = 1'b0;
      m_waited  = 0;
      if (model_hazard()) m_bubbles = LU_BUBBLES - 1;
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic br, input logic rdy);
    i_mem_is_ld   = ld;
    i_mem_is_st   = st;
    i_mem_rd      = rd;
    i_ex_rs1      = rs1;
    i_ex_rs2      = rs2;
    i_ex_use_rs1  = u1;
    i_ex_use_rs2  = u2;
    i_ex_br_taken = br;
    i_dmem_ready  = rdy;
  endtask

  task automatic cyc(input string tag);
    sb_t e;
    e.exp = model_out();
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  // Monitor: one queued expectation per cycle, sampled mid-cycle.
  initial begin
    sb_t        e;
    logic [6:0] act;
    forever begin
      @(negedge i_clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {o_pc_en, o_if_ex_en, o_if_ex_flush, o_ex_mem_en, o_ex_mem_flush,
               o_dmem_req, o_dmem_timeout};
        n_checks++;
        if (act !== e.exp) begin
          n_errors++;
          $display("FAIL %s @%0t: {pc,ifen,iffl,emen,emfl,req,to} got %b expected %b",
                   e.tag, $time, act, e.exp);
        end
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    i_rstn = 1'b0;
    @(posedge i_clk);
    model_step();
    #1;
    cyc("rst_hold");
    i_rstn = 1'b1;

    cyc("idle");
    cyc("idle");

    // load x5, EX reads x5
    drive(1, 0, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1);
    cyc("lu_hit");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (LU_BUBBLES - 1) cyc("lu_bub");
    cyc("lu_done");

    // rs2 hazard with a taken branch that must wait for the bubbles
    drive(1, 0, 5'd9, 5'd3, 5'd9, 1, 1, 1, 1);
    cyc("lu_rs2_br");
    drive(0, 0, 0, 5'd3, 5'd9, 1, 1, 1, 1);
    repeat (LU_BUBBLES - 1) cyc("lu_rs2_bub");
    cyc("br_after_bub");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("br_after_idle");

    // store stalled 3 cycles, then a second store stalled 4 (counter restart)
    drive(0, 1, 5'd0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc("st_wait");
    i_dmem_ready = 1'b1;
    cyc("st_release");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("st_idle");
    drive(0, 1, 5'd0, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc("st_wait2");
    i_dmem_ready = 1'b1;
    cyc("st_release2");

    // branch held in EX while a load waits on memory
    drive(1, 0, 5'd7, 5'd1, 5'd2, 1, 1, 1, 0);
    repeat (3) cyc("br_wait");
    i_dmem_ready = 1'b1;
    cyc("br_release");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("br_gone");

    // x0 destination never stalls
    drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 1);
    cyc("x0_load");
    cyc("x0_load");

    // timeout, then reset clears the flag
    drive(0, 1, 5'd0, 0, 0, 0, 0, 0, 0);
    repeat (MEM_TIMEOUT + 1) cyc("to_wait");
    repeat (3) cyc("to_err");
    i_rstn = 1'b0;
    cyc("to_rst");
    i_rstn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("to_clear");

    // reset in the middle of the bubble train
    drive(1, 0, 5'd12, 5'd12, 5'd0, 1, 0, 0, 1);
    cyc("rb_hit");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("rb_bub");
    i_rstn = 1'b0;
    cyc("rb_rst");
    i_rstn = 1'b1;
    cyc("rb_run");
    cyc("rb_run");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int kind;
      i_rstn        = ($urandom_range(99) != 0);
      kind          = $urandom_range(3);
      i_mem_is_ld   = (kind == 0);
      i_mem_is_st   = (kind == 1);
      i_mem_rd      = 5'($urandom_range(7));
      i_ex_rs1      = 5'($urandom_range(7));
      i_ex_rs2      = 5'($urandom_range(7));
      i_ex_use_rs1  = 1'($urandom_range(1));
      i_ex_use_rs2  = 1'($urandom_range(1));
      i_ex_br_taken = ($urandom_range(3) == 0);
      i_dmem_ready  = ($urandom_range(3) != 0);
      cyc("rand");
    end

    #10;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 3-stage RV32I pipeline (IF -> EX -> MEM/WB). It drives the enable and flush controls of the PC, the IF/EX register and the EX/MEM register. It covers three cases: multi-cycle data-memory accesses, load-use hazards and taken-branch redirects. It also flags data-memory timeouts to the top level.

Parameters:
BIT_WIDTH, 32, datapath width (matches `BIT_WIDTH in param.svh)
MEM_TIMEOUT, 16, max cycles in MEM_WAIT before o_dmem_timeout asserts (>=1)
LU_BUBBLES, 1, bubbles inserted per load-use hazard (1..3)

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  reset, synchronous, active-low
i_mem_is_ld  input  1  instruction in MEM stage is a load
i_mem_is_st  input  1  instruction in MEM stage is a store
i_mem_rd  input  5  destination register of the MEM-stage instruction
i_ex_rs1  input  5  EX-stage source register 1
i_ex_rs2  input  5  EX-stage source register 2
i_ex_use_rs1  input  1  EX instruction reads rs1
i_ex_use_rs2  input  1  EX instruction reads rs2
i_ex_br_taken  input  1  EX branch/jump resolved as taken
i_dmem_ready  input  1  data memory completes the current access this cycle
o_pc_en  output  1  PC update enable
o_if_ex_en  output  1  IF/EX register load enable
o_if_ex_flush  output  1  IF/EX register loads a NOP
o_ex_mem_en  output  1  EX/MEM register load enable
o_ex_mem_flush  output  1  EX/MEM register loads a bubble (rd=0, no mem op)
o_dmem_req  output  1  data memory request
o_dmem_timeout  output  1  sticky timeout error flag

Behaviour:
- State register, 2 bits: RUN, MEM_WAIT, BUBBLE, ERROR. The wait counter is $clog2(MEM_TIMEOUT+1) bits; the bubble counter is 2 bits.
- Reset: i_rstn sampled low at a clock edge sets state=RUN, both counters=0 and o_dmem_timeout=0.
- While i_rstn is low, outputs are forced combinationally: pc_en=0, if_ex_en=0, ex_mem_en=0, both flushes=0, dmem_req=0. Reset mid-operation abandons the current state with no completion.
- mem_op = i_mem_is_ld | i_mem_is_st.
- lu_hazard = i_mem_is_ld & (i_mem_rd != 0) & ((i_ex_use_rs1 & i_ex_rs1 == i_mem_rd) | (i_ex_use_rs2 & i_ex_rs2 == i_mem_rd)).
- Outputs are combinational from state and inputs. o_dmem_req = mem_op in RUN and MEM_WAIT.
- RUN, evaluated in priority order:
  1. mem_op & !i_dmem_ready: all enables=0, flushes=0; next state MEM_WAIT, wait counter=1.
  2. lu_hazard: pc_en=0, if_ex_en=0, ex_mem_en=1, ex_mem_flush=1. The load retires this cycle. Next state BUBBLE with bubble counter=LU_BUBBLES-1; if LU_BUBBLES=1, next state is RUN. i_ex_br_taken is ignored because the branch operands are not yet valid.
  3. i_ex_br_taken: all enables=1, if_ex_flush=1 (the wrong-path fetch is killed); stays RUN.
  4. Otherwise all enables=1, flushes=0.
- A zero-wait access (mem_op & i_dmem_ready in RUN) takes no extra cycle. Rules 2 to 4 then apply in the same cycle.
- MEM_WAIT: all enables=0, o_dmem_req=1.
  - On i_dmem_ready: return to RUN. The release cycle applies the RUN rules 2 to 4 to the held inputs.
  - Otherwise, if wait counter == MEM_TIMEOUT: go to ERROR and set o_dmem_timeout.
  - Otherwise increment the wait counter.
- BUBBLE: pc_en=0, if_ex_en=0, ex_mem_en=1, ex_mem_flush=1. Decrement the counter; at 0, go to RUN.
- ERROR: all enables=0, dmem_req=0. Only reset exits. o_dmem_timeout holds 1.
- A branch that arrives during MEM_WAIT or BUBBLE is not lost. EX is held, so i_ex_br_taken stays asserted and is honoured in the first RUN cycle.
- x0 never causes a hazard.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_BUBBLE, ST_ERROR} pipe_state_t
  - the NOP encoding constant 32'h0000_0013 used by the flush logic
- One sub-module, hazard_detect: purely combinational lu_hazard compare. It is reused by the forwarding logic.

Test Plan:
- Load x5 in MEM, EX add reads x5, dmem_ready=1 -> exactly one cycle with pc_en=0, ex_mem_flush=1, then RUN with all enables=1.
- Store in MEM, dmem_ready low for 3 cycles -> 3 cycles of all-enables-0 with dmem_req=1; release on the 4th cycle; wait counter restarts at 1 on the next access.
- Branch taken while MEM_WAIT (ready after 2 cycles) -> if_ex_flush=1 only in the first RUN cycle after release.
- Load x0 in MEM, EX reads x0 -> no bubble; enables stay 1.
- MEM_TIMEOUT=4, ready never asserts -> o_dmem_timeout=1 on the cycle after wait counter=4, state ERROR; i_rstn low for 1 edge -> RUN, flag cleared.
- i_rstn low during BUBBLE with LU_BUBBLES=3 -> next edge state=RUN, all counters 0, outputs at reset values while i_rstn=0.
